inst_issue_queue: RTL and testbench

- Parametrised successor to the fixed 4-entry fetch/decode/issue path.
- Buffers fetched instructions in an in-order ring queue.
- Each cycle, the head instruction issues when two conditions hold:
  - the ROB can allocate an entry;
  - the reservation station (RS) class decoded from its opcode has space.
- Issue supplies the ROB tag, opcode and destination, and presents the decoded fields to the selected RS.
- Sits between the fetch unit and the ROB/RS array of the Tomasulo core.

---
 rtl/issue_pkg.sv | 50 +++++
 rtl/iq_ring_fifo.sv | 79 +++++++
 rtl/inst_issue_queue.sv | 151 +++++++++++++++
 tb/tb_inst_issue_queue.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// ---------------------------------------------------------------------------
// issue_pkg
// Shared definitions for the instruction issue queue:
//   - bit positions of the opcode/dest/src1/src2 fields inside a 32-bit
//     instruction word
//   - iq_entry_t, the default queue entry layout {inst, pc}
//   - clog2(), a constant-function width helper
//   - decode_cls(), the opcode -> reservation-station class decode
// ---------------------------------------------------------------------------
package issue_pkg;

   localparam int OP_MSB   = 15;
   localparam int OP_LSB   = 12;
   localparam int DEST_MSB = 11;
   localparam int DEST_LSB = 8;
   localparam int SRC1_MSB = 7;
   localparam int SRC1_LSB = 4;
   localparam int SRC2_MSB = 3;
   localparam int SRC2_LSB = 0;

   // Entry layout for the default 4-bit PC. The issue queue builds the same
   // layout locally, with the pc field sized by its PC_W parameter.
   localparam int DEF_PC_W = 4;

   typedef struct packed {
      logic [31:0]         inst;
      logic [DEF_PC_W-1:0] pc;
   } iq_entry_t;

   // Smallest r with 2**r >= value (0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // RS class is opcode[3:2], clamped to the last implemented class.
   function automatic logic [1:0] decode_cls(input logic [3:0] opcode,
                                             input int         num_rs);
      logic [1:0] raw;
      logic [1:0] lim;
      raw = opcode[3:2];
      lim = 2'(num_rs - 1);
      return (raw > lim) ? lim : raw;
   endfunction

endpackage

// File: rtl/iq_ring_fifo.sv
// ---------------------------------------------------------------------------
// iq_ring_fifo
// In-order ring buffer holding queued instructions. No write-to-read bypass:
// an entry written on an edge is visible at rdata only after that edge.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   flush       - synchronous clear of pointers and count (wins over push/pop)
//   push, wdata - write wdata at tail (ignored when full)
//   pop         - advance head (ignored when empty)
//   rdata       - entry at head
//   count       - occupancy 0..DEPTH
//   full, empty - occupancy flags
// ---------------------------------------------------------------------------
module iq_ring_fifo
   import issue_pkg::*;
#(
   parameter  int DEPTH = 4,
   parameter  int W     = 36,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic [AW:0]  count,
   output logic         full,
   output logic         empty
);

   localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rdata   = mem[head];

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= tail + PTR_ONE;
         if (do_pop)  head <= head + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage is cleared on reset so the head fields read as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[tail] <= wdata;
      end
   end

endmodule

// File: rtl/inst_issue_queue.sv
// ---------------------------------------------------------------------------
// inst_issue_queue
// Buffers fetched instructions in order and issues the head instruction to
// the ROB and to the reservation station class decoded from its opcode.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   flush             - synchronous queue clear; drops the same-cycle push
//   f_valid/f_ready   - fetch handshake; f_inst/f_pc carry the instruction
//   rob_ready/rob_tag - ROB free-entry flag and tail tag
//   rob_alloc/op/dest - ROB allocation strobe and written fields
//   rs_ready/rs_valid - per-class RS space flags / one-hot dispatch strobe
//   rs_op/src1/src2/dest/tag/pc - fields presented to the selected RS
//   iq_count/full/empty - queue occupancy
// Optional build macro ISSUE_STATS_EN adds 16-bit saturating counters
// stall_rob_cnt, stall_rs_cnt and issued_cnt.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. f_ready does not depend on f_valid; rob_alloc/rs_valid are
// asserted only when rob_ready and the selected rs_ready are already high,
// so a strobe always denotes a completed transfer.
// ---------------------------------------------------------------------------
module inst_issue_queue
   import issue_pkg::*;
#(
   parameter  int IQ_DEPTH  = 4,
   parameter  int ROB_DEPTH = 32,
   parameter  int NUM_RS    = 3,
   parameter  int PC_W      = 4,
   localparam int ROB_TW    = clog2(ROB_DEPTH),
   localparam int IQ_AW     = clog2(IQ_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              f_valid,
   output logic              f_ready,
   input  logic [31:0]       f_inst,
   input  logic [PC_W-1:0]   f_pc,
   input  logic              rob_ready,
   input  logic [ROB_TW-1:0] rob_tag,
   output logic              rob_alloc,
   output logic [3:0]        rob_op,
   output logic [3:0]        rob_dest,
   input  logic [NUM_RS-1:0] rs_ready,
   output logic [NUM_RS-1:0] rs_valid,
   output logic [3:0]        rs_op,
   output logic [3:0]        rs_src1,
   output logic [3:0]        rs_src2,
   output logic [3:0]        rs_dest,
   output logic [ROB_TW-1:0] rs_tag,
   output logic [PC_W-1:0]   rs_pc,
   output logic [IQ_AW:0]    iq_count,
   output logic              iq_full,
   output logic              iq_empty
`ifdef ISSUE_STATS_EN
   ,
   output logic [15:0]       stall_rob_cnt,
   output logic [15:0]       stall_rs_cnt,
   output logic [15:0]       issued_cnt
`endif
);

   typedef struct packed {
      logic [31:0]     inst;
      logic [PC_W-1:0] pc;
   } entry_t;

   localparam int EW = $bits(entry_t);

   entry_t            wr_entry;
   entry_t            hd_entry;
   logic              push;
   logic              go;
   logic [3:0]        hd_op;
   logic [1:0]        cls;
   logic [NUM_RS-1:0] cls_oh;
   logic              rs_space;
   logic              unused_inst_hi;

   assign wr_entry = '{inst: f_inst, pc: f_pc};
   assign f_ready  = !iq_full;
   assign push     = f_valid && f_ready;

   iq_ring_fifo #(
      .DEPTH (IQ_DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .pop   (go),
      .wdata (wr_entry),
      .rdata (hd_entry),
      .count (iq_count),
      .full  (iq_full),
      .empty (iq_empty)
   );

   // Decode and issue arbitration, all combinational from the head entry.
   always_comb begin
      hd_op  = hd_entry.inst[OP_MSB:OP_LSB];
      cls    = decode_cls(hd_op, NUM_RS);
      cls_oh = '0;
      for (int i = 0; i < NUM_RS; i++) begin
         cls_oh[i] = (cls == 2'(i));
      end
      rs_space = |(rs_ready & cls_oh);
      // Flush masks issue so nothing leaves a queue that is being discarded.
      go       = !iq_empty && rob_ready && rs_space && !flush;
      rs_valid = go ? cls_oh : '0;
   end

   assign rob_alloc = go;
   assign rob_op    = hd_op;
   assign rob_dest  = hd_entry.inst[DEST_MSB:DEST_LSB];
   assign rs_op     = hd_op;
   assign rs_dest   = hd_entry.inst[DEST_MSB:DEST_LSB];
   assign rs_src1   = hd_entry.inst[SRC1_MSB:SRC1_LSB];
   assign rs_src2   = hd_entry.inst[SRC2_MSB:SRC2_LSB];
   assign rs_tag    = rob_tag;
   assign rs_pc     = hd_entry.pc;

   // Upper instruction bits travel through the queue but are not decoded here.
   assign unused_inst_hi = ^hd_entry.inst[31:16];

`ifdef ISSUE_STATS_EN
   logic stall_rob;
   logic stall_rs;

   assign stall_rob = !iq_empty && !rob_ready;
   assign stall_rs  = !iq_empty && rob_ready && !rs_space;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_rob_cnt <= '0;
         stall_rs_cnt  <= '0;
         issued_cnt    <= '0;
      end else if (flush) begin
         stall_rob_cnt <= '0;
         stall_rs_cnt  <= '0;
         issued_cnt    <= '0;
      end else begin
         if (stall_rob && (stall_rob_cnt != 16'hFFFF)) stall_rob_cnt <= stall_rob_cnt + 16'd1;
         if (stall_rs  && (stall_rs_cnt  != 16'hFFFF)) stall_rs_cnt  <= stall_rs_cnt + 16'd1;
         if (go        && (issued_cnt    != 16'hFFFF)) issued_cnt    <= issued_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_issue_queue
// Directed bench for inst_issue_queue. Expected issue records are queued as
// stimulus is applied; a negedge monitor pops and compares on every issue.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_issue_queue;

   localparam int IQ_DEPTH  = 4;
   localparam int ROB_DEPTH = 32;
   localparam int NUM_RS    = 3;
   localparam int PC_W      = 4;
   localparam int ROB_TW    = 5;
   localparam int EW        = NUM_RS + ROB_TW + 16 + PC_W;

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic              f_valid;
   logic              f_ready;
   logic [31:0]       f_inst;
   logic [PC_W-1:0]   f_pc;
   logic              rob_ready;
   logic [ROB_TW-1:0] rob_tag;
   logic              rob_alloc;
   logic [3:0]        rob_op;
   logic [3:0]        rob_dest;
   logic [NUM_RS-1:0] rs_ready;
   logic [NUM_RS-1:0] rs_valid;
   logic [3:0]        rs_op;
   logic [3:0]        rs_src1;
   logic [3:0]        rs_src2;
   logic [3:0]        rs_dest;
   logic [ROB_TW-1:0] rs_tag;
   logic [PC_W-1:0]   rs_pc;
   logic [2:0]        iq_count;
   logic              iq_full;
   logic              iq_empty;
`ifdef ISSUE_STATS_EN
   logic [15:0]       stall_rob_cnt;
   logic [15:0]       stall_rs_cnt;
   logic [15:0]       issued_cnt;
`endif

   inst_issue_queue #(
      .IQ_DEPTH  (IQ_DEPTH),
      .ROB_DEPTH (ROB_DEPTH),
      .NUM_RS    (NUM_RS),
      .PC_W      (PC_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .f_valid   (f_valid),
      .f_ready   (f_ready),
      .f_inst    (f_inst),
      .f_pc      (f_pc),
      .rob_ready (rob_ready),
      .rob_tag   (rob_tag),
      .rob_alloc (rob_alloc),
      .rob_op    (rob_op),
      .rob_dest  (rob_dest),
      .rs_ready  (rs_ready),
      .rs_valid  (rs_valid),
      .rs_op     (rs_op),
      .rs_src1   (rs_src1),
      .rs_src2   (rs_src2),
      .rs_dest   (rs_dest),
      .rs_tag    (rs_tag),
      .rs_pc     (rs_pc),
      .iq_count  (iq_count),
      .iq_full   (iq_full),
      .iq_empty  (iq_empty)
`ifdef ISSUE_STATS_EN
      ,
      .stall_rob_cnt (stall_rob_cnt),
      .stall_rs_cnt  (stall_rs_cnt),
      .issued_cnt    (issued_cnt)
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [EW-1:0] rec(input logic [NUM_RS-1:0] v,
                                         input logic [ROB_TW-1:0] t,
                                         input logic [3:0]        op,
                                         input logic [3:0]        d,
                                         input logic [3:0]        s1,
                                         input logic [3:0]        s2,
                                         input logic [PC_W-1:0]   pc);
      return {v, t, op, d, s1, s2, pc};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares every issue against the head of the expected queue.
   always @(negedge clk) begin
      logic [EW-1:0] act;
      logic [EW-1:0] e;
      if (rst_n) begin
         if (rob_alloc) begin
            act = rec(rs_valid, rs_tag, rob_op, rob_dest, rs_src1, rs_src2, rs_pc);
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL issue_unexpected: got %h expected no issue", act);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  n_fail++;
                  $display("FAIL issue_record: got %h expected %h", act, e);
               end
            end
            n_checks++;
            if ({rs_op, rs_dest} !== {rob_op, rob_dest}) begin
               n_fail++;
               $display("FAIL rs_vs_rob_fields: got %h expected %h", {rs_op, rs_dest}, {rob_op, rob_dest});
            end
         end else begin
            n_checks++;
            if (rs_valid !== '0) begin
               n_fail++;
               $display("FAIL rs_valid_idle: got %b expected 000", rs_valid);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // One clock: a simple ROB model advances its tail tag after each allocation.
   task automatic tick();
      logic a;
      @(negedge clk);
      a = rob_alloc;
      @(posedge clk);
      #1;
      if (a) rob_tag = rob_tag + 5'd1;
   endtask

   task automatic push_inst(input logic [31:0] inst, input logic [PC_W-1:0] pc);
      f_valid = 1'b1;
      f_inst  = inst;
      f_pc    = pc;
      tick();
      f_valid = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [2:0] v;
      rst_n     = 1'b0;
      flush     = 1'b0;
      f_valid   = 1'b0;
      f_inst    = '0;
      f_pc      = '0;
      rob_ready = 1'b0;
      rob_tag   = '0;
      rs_ready  = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      check("rst_count", 32'(iq_count), 0);
      check("rst_empty", 32'(iq_empty), 1);
      check("rst_full", 32'(iq_full), 0);
      check("rst_f_ready", 32'(f_ready), 1);
      check("rst_rob_alloc", 32'(rob_alloc), 0);
      check("rst_rs_valid", 32'(rs_valid), 0);
      check("rst_rob_op", 32'(rob_op), 0);
      check("rst_rs_pc", 32'(rs_pc), 0);
      rst_n = 1'b1;

      // Fill with the ROB stalled; a fifth push is refused
      rs_ready = 3'b111;
      push_inst(32'h0000_1321, 4'h0);
      push_inst(32'h0000_2432, 4'h1);
      push_inst(32'h0000_8543, 4'h2);
      push_inst(32'h0000_C654, 4'h3);
      check("fill_count", 32'(iq_count), 4);
      check("fill_full", 32'(iq_full), 1);
      check("fill_f_ready", 32'(f_ready), 0);
      check("fill_no_alloc", 32'(rob_alloc), 0);
      push_inst(32'h0000_F9AB, 4'hF);
      check("fill_5th_ignored", 32'(iq_count), 4);

      // In-order dispatch: opcodes 1,2 -> class 0; 8,C -> class 2
      rob_tag = 5'd5;
      exp_q.push_back(rec(3'b001, 5'd5, 4'h1, 4'h3, 4'h2, 4'h1, 4'h0));
      exp_q.push_back(rec(3'b001, 5'd6, 4'h2, 4'h4, 4'h3, 4'h2, 4'h1));
      exp_q.push_back(rec(3'b100, 5'd7, 4'h8, 4'h5, 4'h4, 4'h3, 4'h2));
      exp_q.push_back(rec(3'b100, 5'd8, 4'hC, 4'h6, 4'h5, 4'h4, 4'h3));
      rob_ready = 1'b1;
      repeat (4) tick();
      check("dispatch_empty", 32'(iq_empty), 1);
      check("dispatch_count", 32'(iq_count), 0);

      // Head blocking: opcode 8 (class 2) blocked, younger class-0 entry waits
      rs_ready = 3'b011;
      push_inst(32'h0000_8765, 4'h4);
      push_inst(32'h0000_1234, 4'h5);
      check("block_count", 32'(iq_count), 2);
      check("block_no_alloc", 32'(rob_alloc), 0);
      check("block_rs_valid", 32'(rs_valid), 0);
      tick();
      check("block_hold_count", 32'(iq_count), 2);
      check("block_hold_op", 32'(rob_op), 8);
      exp_q.push_back(rec(3'b100, 5'd9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4));
      exp_q.push_back(rec(3'b001, 5'd10, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5));
      rs_ready = 3'b111;
      tick();
      tick();
      check("block_release_empty", 32'(iq_empty), 1);

      // Sustained push/pop at count 2, pointers wrap several times
      rob_ready = 1'b0;
      push_inst(32'h0000_3012, 4'h6);
      push_inst(32'h0000_5A34, 4'h7);
      exp_q.push_back(rec(3'b001, 5'd11, 4'h3, 4'h0, 4'h1, 4'h2, 4'h6));
      exp_q.push_back(rec(3'b010, 5'd12, 4'h5, 4'hA, 4'h3, 4'h4, 4'h7));
      rob_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         v = (i < 4) ? 3'b001 : ((i < 8) ? 3'b010 : 3'b100);
         f_valid = 1'b1;
         f_inst  = {16'h0000, 4'(i), 4'(i + 3), 4'(i + 5), 4'(i + 7)};
         f_pc    = 4'(8 + i);
         exp_q.push_back(rec(v, 5'(13 + i), 4'(i), 4'(i + 3), 4'(i + 5), 4'(i + 7), 4'(8 + i)));
         tick();
         check("stream_count", 32'(iq_count), 2);
      end
      f_valid = 1'b0;
      tick();
      tick();
      check("stream_drained", 32'(iq_empty), 1);

      // Flush with three entries and a concurrent push
      rob_ready = 1'b0;
      push_inst(32'h0000_1111, 4'h1);
      push_inst(32'h0000_2222, 4'h2);
      push_inst(32'h0000_3333, 4'h3);
      check("preflush_count", 32'(iq_count), 3);
      flush     = 1'b1;
      f_valid   = 1'b1;
      f_inst    = 32'h0000_4444;
      rob_ready = 1'b1;
      #1;
      check("flush_no_alloc", 32'(rob_alloc), 0);
      check("flush_no_rs_valid", 32'(rs_valid), 0);
      tick();
      flush   = 1'b0;
      f_valid = 1'b0;
      check("flush_count", 32'(iq_count), 0);
      check("flush_empty", 32'(iq_empty), 1);
      tick();
      check("flush_push_dropped", 32'(iq_count), 0);

      // Asynchronous reset while an issue strobe is up
      rob_ready = 1'b0;
      push_inst(32'h0000_1987, 4'h9);
      exp_q.push_back(rec(3'b001, 5'd23, 4'h1, 4'h9, 4'h8, 4'h7, 4'h9));
      rob_ready = 1'b1;
      @(negedge clk);
      #1;
      check("arst_pre_rs_valid", 32'(rs_valid), 32'b001);
      check("arst_pre_alloc", 32'(rob_alloc), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_rs_valid", 32'(rs_valid), 0);
      check("arst_alloc", 32'(rob_alloc), 0);
      check("arst_count", 32'(iq_count), 0);
      check("arst_empty", 32'(iq_empty), 1);
      check("arst_f_ready", 32'(f_ready), 1);
`ifdef ISSUE_STATS_EN
      check("arst_stall_rob_cnt", 32'(stall_rob_cnt), 0);
      check("arst_stall_rs_cnt", 32'(stall_rs_cnt), 0);
      check("arst_issued_cnt", 32'(issued_cnt), 0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      check("post_rst_count", 32'(iq_count), 0);

      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
